fpu_sequencer: RTL

- Execution-side counterpart of the FPU instruction decoder: consumes the decoded 5-bit fpu_op with its operands and destination register, then dispatches the operation.
- Dispatch targets: one of four external FP units (add/sub, mul, div/sqrt, convert), or the block handles fmv moves internally.
- Waits for unit completion with a timeout, then returns the result to the writeback stage over a valid/ready pair.
- Sits between the decode/issue stage and the FP/integer writeback mux.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_op_class.sv | 23 ++
 rtl/fpu_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU encodings: fpu_op values, unit indices, sequencer state and op-class bundle.
// Used by the decoder, the sequencer and hazard logic.
package fpu_pkg;

  localparam logic [4:0] FADD    = 5'b00000;
  localparam logic [4:0] FSUB    = 5'b00001;
  localparam logic [4:0] FMUL    = 5'b00010;
  localparam logic [4:0] FDIV    = 5'b00011;
  localparam logic [4:0] FSQRT   = 5'b00100;
  localparam logic [4:0] FCVT_LD = 5'b00101;
  localparam logic [4:0] FCVT_DL = 5'b00110;
  localparam logic [4:0] FMV_XD  = 5'b00111;
  localparam logic [4:0] FMV_DX  = 5'b01000;
  localparam logic [4:0] FOP_INV = 5'b11111;

  localparam int U_ADD     = 0;
  localparam int U_MUL     = 1;
  localparam int U_DIV     = 2;
  localparam int U_CVT     = 3;
  localparam int NUM_UNITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [NUM_UNITS-1:0] unit_sel;   // one-hot target unit, zero for move/illegal
    logic                 is_move;
    logic                 is_illegal;
    logic                 to_int;
  } op_class_t;

endpackage

// File: rtl/fpu_op_class.sv
// Combinational fpu_op classifier: target unit one-hot, move/illegal flags and
// integer-destination flag.
module fpu_op_class
  import fpu_pkg::*;
(
  input  logic [4:0] i_op,
  output op_class_t  o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      FADD, FSUB:       o_cls.unit_sel[U_ADD] = 1'b1;
      FMUL:             o_cls.unit_sel[U_MUL] = 1'b1;
      FDIV, FSQRT:      o_cls.unit_sel[U_DIV] = 1'b1;
      FCVT_LD, FCVT_DL: o_cls.unit_sel[U_CVT] = 1'b1;
      FMV_XD, FMV_DX:   o_cls.is_move         = 1'b1;
      default:          o_cls.is_illegal      = 1'b1;
    endcase
    o_cls.to_int = (i_op == FCVT_LD) || (i_op == FMV_XD);
  end

endmodule

// File: rtl/fpu_sequencer.sv
// FPU execution sequencer: dispatches a decoded op to one of four FP units (or
// handles fmv locally), waits for completion with a timeout, returns the result.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [4:0]                i_req_op,
  input  logic [XLEN-1:0]           i_req_rs1,
  input  logic [XLEN-1:0]           i_req_rs2,
  input  logic [4:0]                i_req_rd,
  output logic [NUM_UNITS-1:0]      o_unit_start,
  output logic [4:0]                o_unit_op,
  output logic [XLEN-1:0]           o_unit_a,
  output logic [XLEN-1:0]           o_unit_b,
  input  logic [NUM_UNITS-1:0]      i_unit_done,
  input  logic [NUM_UNITS*XLEN-1:0] i_unit_result,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [XLEN-1:0]           o_rsp_data,
  output logic [4:0]                o_rsp_rd,
  output logic                      o_rsp_to_int,
  output logic                      o_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t           r_state;
  logic [NUM_UNITS-1:0] r_unit_start;
  logic [NUM_UNITS-1:0] r_sel;
  logic [4:0]           r_op;
  logic [XLEN-1:0]      r_a;
  logic [XLEN-1:0]      r_b;
  logic [4:0]           r_rd;
  logic                 r_to_int;
  logic                 r_rsp_valid;
  logic [XLEN-1:0]      r_rsp_data;
  logic                 r_rsp_err;
  logic [CNT_W-1:0]     r_cnt;

  op_class_t                        w_cls;
  logic                             w_done;
  logic                             w_timeout;
  logic [NUM_UNITS-1:0][XLEN-1:0]   w_res_masked;
  logic [XLEN-1:0]                  w_res;

  fpu_op_class u_op_class (
    .i_op  (i_req_op),
    .o_cls (w_cls)
  );

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_res
    assign w_res_masked[k] = r_sel[k] ? i_unit_result[k*XLEN +: XLEN] : '0;
  end

  always_comb begin
    w_res = '0;
    for (int k = 0; k < NUM_UNITS; k++) w_res = w_res | w_res_masked[k];
  end

  // Done is only honoured on the selected unit and never in the start-pulse cycle.
  assign w_done      = (|(i_unit_done & r_sel)) && (r_unit_start == '0);
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_req_ready = (r_state == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_unit_start <= '0;
      r_sel        <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rd         <= '0;
      r_to_int     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_unit_start <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_op     <= i_req_op;
            r_a      <= i_req_rs1;
            r_b      <= i_req_rs2;
            r_rd     <= i_req_rd;
            r_to_int <= w_cls.to_int;
            r_sel    <= w_cls.unit_sel;
            r_cnt    <= '0;
            if (w_cls.is_move) begin
              r_rsp_data  <= i_req_rs1;
              r_rsp_err   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else if (w_cls.is_illegal) begin
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_unit_start <= w_cls.unit_sel;
              r_state      <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_rsp_data  <= w_res;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_unit_start = r_unit_start;
  assign o_unit_op    = r_op;
  assign o_unit_a     = r_a;
  assign o_unit_b     = r_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_rd     = r_rd;
  assign o_rsp_to_int = r_to_int;
  assign o_rsp_err    = r_rsp_err;

endmodule
